// File: rtl/linescanner_stream_pkg.sv
// Shared types and sizing helpers for the line-scanner stream packer and its FIFO.
package linescanner_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_DROP = 2'd2,
        S_MARK = 2'd3
    } state_t;

    localparam int DEF_PIXEL_WIDTH   = 8;
    localparam int DEF_AXI_BUS_WIDTH = 32;
    localparam int DEF_LINE_LENGTH   = 1024;
    localparam int DEF_FIFO_DEPTH    = 16;
    localparam int STRB_W            = DEF_AXI_BUS_WIDTH / 8;
    localparam int CNT_W             = $clog2(DEF_LINE_LENGTH);

    function automatic int calc_ppw(input int bus_w, input int pix_w);
        return bus_w / pix_w;
    endfunction

    function automatic int calc_strb_w(input int bus_w);
        return bus_w / 8;
    endfunction

    // Width of an index into n items, never below one bit
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_cnt_w(input int line_len);
        return calc_idx_w(line_len);
    endfunction

endpackage

// File: rtl/linescanner_stream_fifo.sv
// First-word-fall-through FIFO: a pushed word is visible the cycle after the push edge.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module linescanner_stream_fifo
    import linescanner_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = calc_idx_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero while empty so the stream outputs idle at 0
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/linescanner_stream_packer.sv
// Packs strobed pixels LSB-first into AXI-Stream words through an FWFT FIFO; tvalid one cycle after the completing pixel.
// FIFO full without pop drops the rest of the line and ends it with a marker word. LINESCANNER_STREAM_TUSER_SOL_EN adds tuser.
module linescanner_stream_packer
    import linescanner_stream_pkg::*;
#(
    parameter int PIXEL_WIDTH   = DEF_PIXEL_WIDTH,
    parameter int AXI_BUS_WIDTH = DEF_AXI_BUS_WIDTH,
    parameter int LINE_LENGTH   = DEF_LINE_LENGTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                       m00_axis_aclk,
    input  logic                       m00_axis_areset,
    input  logic                       enable,
    input  logic [PIXEL_WIDTH-1:0]     input_data,
    input  logic                       pixel_captured,
    output logic                       m00_axis_tvalid,
    input  logic                       m00_axis_tready,
    output logic [AXI_BUS_WIDTH-1:0]   m00_axis_tdata,
    output logic [AXI_BUS_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                       m00_axis_tlast,
`ifdef LINESCANNER_STREAM_TUSER_SOL_EN
    output logic                       m00_axis_tuser,
`endif
    output logic                       overflow,
    output logic [15:0]                overflow_count
);

    localparam int PPW = calc_ppw(AXI_BUS_WIDTH, PIXEL_WIDTH);
    localparam int SW  = calc_strb_w(AXI_BUS_WIDTH);
    localparam int CW  = calc_cnt_w(LINE_LENGTH);
    localparam int KW  = calc_idx_w(PPW);
`ifdef LINESCANNER_STREAM_TUSER_SOL_EN
    localparam int FW  = AXI_BUS_WIDTH + SW + 2;
`else
    localparam int FW  = AXI_BUS_WIDTH + SW + 1;
`endif
    localparam logic [CW-1:0] CNT_LAST  = CW'(LINE_LENGTH - 1);
    localparam logic [KW-1:0] SLOT_LAST = KW'(PPW - 1);

    state_t                   state;
    logic [CW-1:0]            pix_cnt;
    logic [CW-1:0]            cnt_next;
    logic [KW-1:0]            slot;
    logic [AXI_BUS_WIDTH-1:0] word_buf;
    logic [AXI_BUS_WIDTH-1:0] word_next;
    logic                     sol;

    logic                     accept;
    logic                     line_end;
    logic                     packing;
    logic                     word_done;
    logic                     pop;
    logic                     push_ok;
    logic                     push_req;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [AXI_BUS_WIDTH-1:0] push_tdata;
    logic [SW-1:0]            push_tstrb;
    logic [SW-1:0]            end_strb;
    logic                     push_tlast;
    logic [FW-1:0]            fifo_in;
    logic [FW-1:0]            fifo_out;

    assign accept    = enable && pixel_captured;
    assign line_end  = (pix_cnt == CNT_LAST);
    assign cnt_next  = !accept ? pix_cnt : (line_end ? '0 : pix_cnt + CW'(1));
    // S_IDLE behaves as S_PACK on the first enabled edge so a strobe there is not lost
    assign packing   = (state == S_IDLE) || (state == S_PACK);
    assign word_done = accept && packing && (line_end || slot == SLOT_LAST);
    assign pop       = m00_axis_tvalid && m00_axis_tready;
    assign push_ok   = !fifo_full || pop;

    always_comb begin
        word_next = word_buf;
        word_next[int'(slot)*PIXEL_WIDTH +: PIXEL_WIDTH] = input_data;
    end

    always_comb begin
        end_strb = '0;
        for (int b = 0; b < SW; b++) begin
            end_strb[b] = (b * 8 < (int'(slot) + 1) * PIXEL_WIDTH);
        end
    end

    always_comb begin
        push_req   = 1'b0;
        push_tdata = word_next;
        push_tstrb = line_end ? end_strb : '1;
        push_tlast = line_end;
        if (enable && state == S_MARK) begin
            push_req   = 1'b1;
            push_tdata = '0;
            push_tstrb = '0;
            push_tlast = 1'b1;
        end else if (word_done) begin
            push_req   = 1'b1;
        end
    end

`ifdef LINESCANNER_STREAM_TUSER_SOL_EN
    logic push_tuser;
    assign push_tuser = sol && (state != S_MARK);
    assign fifo_in    = {push_tuser, push_tlast, push_tstrb, push_tdata};
    assign {m00_axis_tuser, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = fifo_out;
`else
    assign fifo_in    = {push_tlast, push_tstrb, push_tdata};
    assign {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = fifo_out;
`endif

    assign m00_axis_tvalid = !fifo_empty;

    linescanner_stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (m00_axis_aclk),
        .rst       (m00_axis_areset),
        .push      (push_req && push_ok),
        .push_data (fifo_in),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state          <= S_IDLE;
            pix_cnt        <= '0;
            slot           <= '0;
            word_buf       <= '0;
            sol            <= 1'b1;
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else if (!enable) begin
            // Aborted line: partial word and position are forgotten, queued words still drain
            state    <= S_IDLE;
            pix_cnt  <= '0;
            slot     <= '0;
            word_buf <= '0;
            sol      <= 1'b1;
        end else begin
            pix_cnt <= cnt_next;
            case (state)
                S_IDLE, S_PACK: begin
                    state <= S_PACK;
                    if (word_done) begin
                        slot     <= '0;
                        word_buf <= '0;
                        sol      <= line_end;
                        if (!push_ok) begin
                            overflow <= 1'b1;
                            if (overflow_count != 16'hFFFF) begin
                                overflow_count <= overflow_count + 16'd1;
                            end
                            state <= line_end ? S_MARK : S_DROP;
                        end
                    end else if (accept) begin
                        slot     <= slot + KW'(1);
                        word_buf <= word_next;
                    end
                end
                S_DROP: begin
                    if (accept && line_end) begin
                        state <= S_MARK;
                        sol   <= 1'b1;
                    end
                end
                S_MARK: begin
                    if (push_ok) begin
                        state <= (cnt_next == '0) ? S_PACK : S_DROP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
